// File: rtl/serial_add_ctrl_if.sv
// serial_add_ctrl_if: groups the request/operand and result/status signals
// of the bit-serial add/subtract sequencer.
//   master : drives start, sub, a, b; observes busy, done, result, c_out, overflow, zero
//   slave  : the sequencer side (mirror of master)
interface serial_add_ctrl_if #(
  parameter int WIDTH = 32
);
  logic             start;
  logic             sub;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] result;
  logic             c_out;
  logic             overflow;
  logic             zero;

  modport master (
    output start, sub, a, b,
    input  busy, done, result, c_out, overflow, zero
  );

  modport slave (
    input  start, sub, a, b,
    output busy, done, result, c_out, overflow, zero
  );
endinterface

// File: rtl/serial_add_ctrl.sv
// serial_add_ctrl: bit-serial add/subtract sequencer around one add_1b cell.
// Ports: clk, rst (async, active-high), bus (serial_add_ctrl_if.slave):
//   start/sub/a/b request in; busy/done/result/c_out/overflow/zero out.
// Optional feature macro: SERIAL_ADD_FLAGS_EN enables the overflow/zero flags;
// when undefined, overflow and zero are tied to 0.

// add_1b: single-bit full adder.
// Latency: combinational.
// Backpressure: none.
module add_1b (
  input  logic a,
  input  logic b,
  input  logic c_in,
  output logic sum,
  output logic c_out
);
  assign sum   = a ^ b ^ c_in;
  assign c_out = (a & b) | (c_in & (a ^ b));
endmodule

// serial_add_ctrl: WIDTH-bit add/sub, one bit per clock, LSB first.
// Latency: WIDTH+1 cycles from start acceptance to the done pulse.
// Backpressure: start is only sampled in IDLE/DONE; start during RUN is ignored.
module serial_add_ctrl #(
  parameter int WIDTH = 32
) (
  input  logic               clk,
  input  logic               rst,
  serial_add_ctrl_if.slave   bus
);
  localparam int CW = $clog2(WIDTH);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t           state_q,  state_d;
  logic [WIDTH-1:0] a_sh_q,   a_sh_d;
  logic [WIDTH-1:0] b_sh_q,   b_sh_d;
  logic [WIDTH-1:0] work_q,   work_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic [CW-1:0]    cnt_q,    cnt_d;
  logic             carry_q,  carry_d;
  logic             c_out_q,  c_out_d;
  logic             busy_q,   busy_d;
  logic             done_q,   done_d;
`ifdef SERIAL_ADD_FLAGS_EN
  logic             any_q,    any_d;
  logic             ovf_q,    ovf_d;
  logic             zero_q,   zero_d;
`endif

  logic             cell_sum;
  logic             cell_cout;
  logic             last_bit;
  logic [WIDTH-1:0] work_next;

  // The only arithmetic in the block: operand LSBs plus the carry flop.
  add_1b u_add (
    .a     (a_sh_q[0]),
    .b     (b_sh_q[0]),
    .c_in  (carry_q),
    .sum   (cell_sum),
    .c_out (cell_cout)
  );

  assign last_bit  = (cnt_q == CW'(WIDTH - 1));
  // Sum bits enter at the MSB, so after WIDTH shifts the first bit sits at bit 0.
  assign work_next = {cell_sum, work_q[WIDTH-1:1]};

  always_comb begin
    state_d  = state_q;
    a_sh_d   = a_sh_q;
    b_sh_d   = b_sh_q;
    work_d   = work_q;
    result_d = result_q;
    cnt_d    = cnt_q;
    carry_d  = carry_q;
    c_out_d  = c_out_q;
    busy_d   = 1'b0;
    done_d   = 1'b0;
`ifdef SERIAL_ADD_FLAGS_EN
    any_d    = any_q;
    ovf_d    = ovf_q;
    zero_d   = zero_q;
`endif
    case (state_q)
      S_RUN: begin
        a_sh_d  = a_sh_q >> 1;
        b_sh_d  = b_sh_q >> 1;
        carry_d = cell_cout;
        work_d  = work_next;
        cnt_d   = cnt_q + 1'b1;
        busy_d  = 1'b1;
`ifdef SERIAL_ADD_FLAGS_EN
        any_d   = any_q | cell_sum;
`endif
        if (last_bit) begin
          result_d = work_next;
          c_out_d  = cell_cout;
          state_d  = S_DONE;
          busy_d   = 1'b0;
          done_d   = 1'b1;
`ifdef SERIAL_ADD_FLAGS_EN
          // On the last bit, carry_q is exactly the carry into the MSB.
          ovf_d    = carry_q ^ cell_cout;
          zero_d   = ~(any_q | cell_sum);
`endif
        end
      end
      default: begin
        // IDLE and DONE behave alike: start launches a new operation,
        // which also gives back-to-back issue straight out of DONE.
        if (bus.start) begin
          a_sh_d  = bus.a;
          // Subtract as A + ~B + 1: invert B and seed the carry with 1.
          b_sh_d  = bus.sub ? ~bus.b : bus.b;
          carry_d = bus.sub;
          cnt_d   = '0;
          state_d = S_RUN;
          busy_d  = 1'b1;
`ifdef SERIAL_ADD_FLAGS_EN
          any_d   = 1'b0;
`endif
        end else begin
          state_d = S_IDLE;
        end
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= S_IDLE;
      a_sh_q   <= '0;
      b_sh_q   <= '0;
      work_q   <= '0;
      result_q <= '0;
      cnt_q    <= '0;
      carry_q  <= 1'b0;
      c_out_q  <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
`ifdef SERIAL_ADD_FLAGS_EN
      any_q    <= 1'b0;
      ovf_q    <= 1'b0;
      zero_q   <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      a_sh_q   <= a_sh_d;
      b_sh_q   <= b_sh_d;
      work_q   <= work_d;
      result_q <= result_d;
      cnt_q    <= cnt_d;
      carry_q  <= carry_d;
      c_out_q  <= c_out_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
`ifdef SERIAL_ADD_FLAGS_EN
      any_q    <= any_d;
      ovf_q    <= ovf_d;
      zero_q   <= zero_d;
`endif
    end
  end

  assign bus.busy   = busy_q;
  assign bus.done   = done_q;
  assign bus.result = result_q;
  assign bus.c_out  = c_out_q;
`ifdef SERIAL_ADD_FLAGS_EN
  assign bus.overflow = ovf_q;
  assign bus.zero     = zero_q;
`else
  assign bus.overflow = 1'b0;
  assign bus.zero     = 1'b0;
`endif
endmodule

// File: tb/tb_serial_add_ctrl.sv
module tb_serial_add_ctrl;
  localparam int W = 8;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc = 0;
  int   n_tests = 0;
  int   n_fail  = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  serial_add_ctrl_if #(.WIDTH(W)) bus ();

  serial_add_ctrl #(.WIDTH(W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct {
    logic [W-1:0] res;
    logic         c;
    logic         ov;
    logic         z;
    int           cyc;
  } exp_t;

  exp_t sb[$];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // Flags only exist in the flag-enabled build; otherwise they must read 0.
  function automatic logic flag(input logic v);
`ifdef SERIAL_ADD_FLAGS_EN
    return v;
`else
    return 1'b0 & v;
`endif
  endfunction

  function automatic void push_exp(input logic [W-1:0] er, input logic ec,
                                   input logic eo, input logic ez, input int c);
    exp_t e;
    e.res = er; e.c = ec; e.ov = flag(eo); e.z = flag(ez); e.cyc = c;
    sb.push_back(e);
  endfunction

  // Monitor: compares every done pulse against the scoreboard head.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (!rst) begin
        if (bus.busy && bus.done) chk("busy_done_exclusive", 1, 0);
        if (bus.done) begin
          if (sb.size() == 0) begin
            chk("unexpected_done", 1, 0);
          end else begin
            e = sb.pop_front();
            chk("result",   bus.result,   e.res);
            chk("c_out",    bus.c_out,    e.c);
            chk("overflow", bus.overflow, e.ov);
            chk("zero",     bus.zero,     e.z);
            chk("latency",  cyc,          e.cyc);
          end
        end
      end
    end
  end

  // Called at a negedge with the DUT in IDLE/DONE; the next posedge accepts.
  task automatic issue(input logic [W-1:0] ia, input logic [W-1:0] ib, input logic is,
                       input logic [W-1:0] er, input logic ec, input logic eo,
                       input logic ez, input bit expect_done);
    bus.start = 1'b1; bus.a = ia; bus.b = ib; bus.sub = is;
    if (expect_done) push_exp(er, ec, eo, ez, cyc + 1 + W);
    @(negedge clk);
    // Scramble operands: the DUT must have captured them already.
    bus.start = 1'b0; bus.a = 8'h5A; bus.b = 8'hC3; bus.sub = ~is;
  endtask

  task automatic wait_done(input string nm);
    int t = 0;
    while (!bus.done && t < 40) begin
      @(negedge clk);
      t++;
    end
    if (!bus.done) chk({nm, "_timeout"}, 0, 1);
    @(negedge clk);
  endtask

  task automatic chk_all_zero(input string nm);
    chk({nm, "_busy"},     bus.busy,     0);
    chk({nm, "_done"},     bus.done,     0);
    chk({nm, "_result"},   bus.result,   0);
    chk({nm, "_c_out"},    bus.c_out,    0);
    chk({nm, "_overflow"}, bus.overflow, 0);
    chk({nm, "_zero"},     bus.zero,     0);
  endtask

  initial begin
    bus.start = 1'b0; bus.sub = 1'b0; bus.a = '0; bus.b = '0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk_all_zero("reset");

    // Basic add and add-side flags.
    issue(8'h05, 8'h03, 1'b0, 8'h08, 1'b0, 1'b0, 1'b0, 1'b1); wait_done("add_05_03");
    issue(8'h7F, 8'h01, 1'b0, 8'h80, 1'b0, 1'b1, 1'b0, 1'b1); wait_done("add_7f_01");
    issue(8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 1'b1); wait_done("add_ff_01");

    // Subtraction.
    issue(8'h05, 8'h05, 1'b1, 8'h00, 1'b1, 1'b0, 1'b1, 1'b1); wait_done("sub_05_05");
    issue(8'h03, 8'h05, 1'b1, 8'hFE, 1'b0, 1'b0, 1'b0, 1'b1); wait_done("sub_03_05");
    issue(8'h80, 8'h01, 1'b1, 8'h7F, 1'b1, 1'b1, 1'b0, 1'b1); wait_done("sub_80_01");

    // start re-pulsed mid-RUN must be ignored; busy stays high for W cycles.
    issue(8'h12, 8'h34, 1'b0, 8'h46, 1'b0, 1'b0, 1'b0, 1'b1);
    for (int i = 0; i < W; i++) begin
      chk("restart_busy", bus.busy, 1);
      if (i == 2) begin bus.start = 1'b1; bus.a = 8'hAA; bus.b = 8'h11; end
      if (i == 3) bus.start = 1'b0;
      @(negedge clk);
    end
    wait_done("restart");

    // start held high: two results W+1 cycles apart, busy low only on done.
    begin
      int k;
      k = cyc + 1;
      bus.start = 1'b1; bus.a = 8'h40; bus.b = 8'h40; bus.sub = 1'b0;
      push_exp(8'h80, 1'b0, 1'b1, 1'b0, k + W);
      push_exp(8'h10, 1'b1, 1'b0, 1'b0, k + 2 * W + 1);
      @(negedge clk);
      bus.a = 8'hC0; bus.b = 8'h50;
      for (int i = 0; i <= 2 * W + 1; i++) begin
        chk("held_busy", bus.busy, (i != W && i != 2 * W + 1) ? 1 : 0);
        if (i == W + 1) begin bus.start = 1'b0; bus.a = 8'h00; bus.b = 8'h00; end
        @(negedge clk);
      end
    end
    @(negedge clk);

    // Reset in the middle of RUN: no done, everything cleared.
    issue(8'h7F, 8'h01, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0);
    repeat (3) @(negedge clk);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk_all_zero("mid_run_reset");
    repeat (W + 2) @(negedge clk);
    chk("mid_run_reset_idle_done", bus.done, 0);
    issue(8'h10, 8'h20, 1'b0, 8'h30, 1'b0, 1'b0, 1'b0, 1'b1); wait_done("after_reset");

    repeat (2) @(negedge clk);
    chk("scoreboard_empty", sb.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation did not finish, expected completion");
    n_fail++;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $fatal(1, "watchdog");
  end
endmodule
